// File: rtl/cisc_pkg.sv
// Shared CISC definitions: opcode constants, fetch/decode FSM states and instruction length.
// The HALT state only exists when CISC_FETCH_ILLEGAL_TRAP_EN is defined.
package cisc_pkg;

  localparam logic [7:0] OP_ADD = 8'h00;
  localparam logic [7:0] OP_SUB = 8'h01;
  localparam logic [7:0] OP_AND = 8'h02;
  localparam logic [7:0] OP_OR  = 8'h03;
  localparam logic [7:0] OP_XOR = 8'h04;
  localparam logic [7:0] OP_NOT = 8'h05;
  localparam logic [7:0] OP_JMP = 8'h10;

  typedef enum logic [2:0] {
    ST_OP    = 3'd0,
    ST_B1    = 3'd1,
    ST_B2    = 3'd2,
    ST_B3    = 3'd3,
    ST_ISSUE = 3'd4
`ifdef CISC_FETCH_ILLEGAL_TRAP_EN
    ,
    ST_HALT  = 3'd5
`endif
  } state_e;

  // Encoded length in bytes; illegal opcodes report 1.
  function automatic logic [2:0] instr_len(input logic [7:0] op);
    if (op <= OP_XOR)      return 3'd4;
    else if (op == OP_NOT) return 3'd3;
    else if (op == OP_JMP) return 3'd2;
    else                   return 3'd1;
  endfunction

endpackage

// File: rtl/cisc_opcode_len.sv
// Combinational opcode classifier: byte length, jump flag and illegal flag.
import cisc_pkg::*;

module cisc_opcode_len (
  input  logic [7:0] op,
  output logic [2:0] len,
  output logic       is_jmp,
  output logic       is_illegal
);

  always_comb begin
    len        = instr_len(op);
    is_jmp     = (op == OP_JMP);
    is_illegal = (instr_len(op) == 3'd1);
  end

endmodule

// File: rtl/cisc_fetch_decode.sv
// Byte-serial instruction fetch and decode front end with internal JMP resolution.
// Optional illegal-opcode trap selected by the CISC_FETCH_ILLEGAL_TRAP_EN macro.
import cisc_pkg::*;

module cisc_fetch_decode #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [7:0]        opcode,
  output logic [7:0]        operand1,
  output logic [7:0]        operand2,
  output logic [7:0]        operand3,
  output logic [ADDR_W-1:0] pc,
  output logic              illegal,
  output logic [2:0]        dbg_state
);

  // Handshake: a bundle transfers on a rising edge where dec_valid and dec_ready are
  // both high; a byte transfers on a rising edge where mem_req and mem_ack are both high.
  state_e     state;
  logic [2:0] len_q;
  logic       jmp_q;
  logic [2:0] offset;
  logic [2:0] dec_len;
  logic       dec_jmp;
  logic       dec_illegal;

  cisc_opcode_len u_len (
    .op         (mem_rdata),
    .len        (dec_len),
    .is_jmp     (dec_jmp),
    .is_illegal (dec_illegal)
  );

`ifdef CISC_FETCH_ILLEGAL_TRAP_EN
  logic illegal_q;
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  always_comb begin
    offset = 3'd0;
    case (state)
      ST_B1:   offset = 3'd1;
      ST_B2:   offset = 3'd2;
      ST_B3:   offset = len_q - 3'd1;
      default: offset = 3'd0;
    endcase
  end

  // Gated by rst_n so the request drops the moment reset asserts, even though state is OP.
  assign mem_req   = rst_n && (state inside {ST_OP, ST_B1, ST_B2, ST_B3});
  assign mem_addr  = pc + ADDR_W'(offset);
  assign dec_valid = (state == ST_ISSUE);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_OP;
      pc       <= RESET_PC;
      opcode   <= 8'h00;
      operand1 <= 8'h00;
      operand2 <= 8'h00;
      operand3 <= 8'h00;
      len_q    <= 3'd0;
      jmp_q    <= 1'b0;
`ifdef CISC_FETCH_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      case (state)
        ST_OP: if (mem_ack) begin
          opcode   <= mem_rdata;
          operand1 <= 8'h00;
          operand2 <= 8'h00;
          operand3 <= 8'h00;
          len_q    <= dec_len;
          jmp_q    <= dec_jmp;
          if (dec_illegal) begin
`ifdef CISC_FETCH_ILLEGAL_TRAP_EN
            illegal_q <= 1'b1;
            state     <= ST_HALT;
`else
            state <= ST_ISSUE;
`endif
          end else begin
            state <= ST_B1;
          end
        end
        ST_B1: if (mem_ack) begin
          if (jmp_q) begin
            pc    <= ADDR_W'(mem_rdata);
            state <= ST_OP;
          end else begin
            operand1 <= mem_rdata;
            state    <= (len_q == 3'd3) ? ST_B3 : ST_B2;
          end
        end
        ST_B2: if (mem_ack) begin
          operand2 <= mem_rdata;
          state    <= ST_B3;
        end
        ST_B3: if (mem_ack) begin
          operand3 <= {4'h0, mem_rdata[3:0]};
          state    <= ST_ISSUE;
        end
        ST_ISSUE: if (dec_ready) begin
          pc    <= pc + ADDR_W'(len_q);
          state <= ST_OP;
        end
`ifdef CISC_FETCH_ILLEGAL_TRAP_EN
        ST_HALT: state <= ST_HALT;
`endif
        default: state <= ST_OP;
      endcase
    end
  end

endmodule

// File: tb/tb_cisc_fetch_decode.sv
// Randomized bench for cisc_fetch_decode against a program-interpreter reference model.
// Builds with or without CISC_FETCH_ILLEGAL_TRAP_EN.
module tb_cisc_fetch_decode;
  import cisc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_req, mem_ack, dec_valid, dec_ready, illegal;
  logic [7:0]  mem_addr, mem_rdata, opcode, operand1, operand2, operand3, pc;
  logic [2:0]  dbg_state;
  logic [39:0] bundle;

  always #5 clk = ~clk;

  cisc_fetch_decode #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .dec_valid(dec_valid),
    .dec_ready(dec_ready), .opcode(opcode), .operand1(operand1),
    .operand2(operand2), .operand3(operand3), .pc(pc), .illegal(illegal),
    .dbg_state(dbg_state)
  );

  assign bundle = {pc, opcode, operand1, operand2, operand3};

  logic [7:0]  mem [256];
  logic [39:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          wait_min = 0, wait_max = 0, ready_pct = 100;
  bit          spurious = 0;
  int          wait_left = 0;
  bit          pend = 0;
  logic [7:0]  pend_addr;
  bit          held_vld = 0;
  logic [39:0] held_val;
  logic [7:0]  model_next_pc, model_halt_pc;
  bit          model_halt, model_jmp_stall;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rd(input logic [7:0] a);
    return mem[a];
  endfunction

  // Interprets the program in mem from start and queues up to n issued bundles.
  task automatic model_run(input logic [7:0] start, input int n);
    logic [7:0] p, op, a, b, d;
    int cnt, jmps, len;
    p = start; cnt = 0; jmps = 0;
    model_halt = 0; model_jmp_stall = 0;
    while (cnt < n && !model_halt && !model_jmp_stall) begin
      op = rd(p);
      if (op == 8'h10) begin
        p = rd(p + 8'd1);
        jmps++;
        model_jmp_stall = (jmps > 16);
      end else if (op <= 8'h05) begin
        len = (op == 8'h05) ? 3 : 4;
        a = rd(p + 8'd1);
        b = (len == 3) ? 8'h00 : rd(p + 8'd2);
        d = rd(p + 8'(len - 1)) & 8'h0f;
        exp_q.push_back({p, op, a, b, d});
        p = p + 8'(len);
        cnt++; jmps = 0;
      end else begin
`ifdef CISC_FETCH_ILLEGAL_TRAP_EN
        model_halt = 1;
        model_halt_pc = p;
`else
        exp_q.push_back({p, op, 24'h0});
        p = p + 8'd1;
        cnt++; jmps = 0;
`endif
      end
    end
    model_next_pc = p;
  endtask

  // Memory responder and execute-stage sink, both acting on the falling edge.
  initial begin
    mem_ack = 1'b0; mem_rdata = 8'h00; dec_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mem_ack = 1'b0; dec_ready = 1'b0; pend = 0; held_vld = 0;
        wait_left = $urandom_range(wait_max, wait_min);
      end else begin
        if (pend) check("addr_hold", {mem_req, mem_addr}, {1'b1, pend_addr});
        if (mem_req && wait_left == 0) begin
          mem_ack = 1'b1;
          mem_rdata = mem[mem_addr];
          wait_left = $urandom_range(wait_max, wait_min);
          pend = 0;
        end else begin
          mem_ack = mem_req ? 1'b0 : (spurious && $urandom_range(1, 0) == 1);
          mem_rdata = 8'($urandom);
          if (mem_req) wait_left--;
          pend = mem_req;
          pend_addr = mem_addr;
        end
        dec_ready = (exp_q.size() > 0) && ($urandom_range(99, 0) < ready_pct);
        if (held_vld) check("hold", {dec_valid, bundle}, {1'b1, held_val});
        if (dec_valid && dec_ready) check("bundle", bundle, exp_q.pop_front());
        held_vld = dec_valid && !dec_ready;
        held_val = bundle;
      end
    end
  end

  task automatic assert_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    exp_q.delete();
  endtask

  task automatic release_reset();
    @(posedge clk); #2;
    rst_n = 1'b1;
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (exp_q.size() > 0 && k < budget);
    check("drain_timeout", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic check_end();
    int k;
    if (model_halt) begin
      k = 0;
      while (!illegal && k < 200) begin
        @(posedge clk); #1;
        k++;
      end
      check("halt_reached", illegal, 1);
      repeat (20) begin
        @(posedge clk); #1;
        check("halt_quiet", {mem_req, dec_valid, pc}, {2'b00, model_halt_pc});
      end
    end else begin
      if (!model_jmp_stall) check("next_pc", pc, model_next_pc);
      check("illegal_low", illegal, 0);
    end
  endtask

  task automatic fill_random();
    int s;
    for (int i = 0; i < 256; i++) begin
      s = $urandom_range(9, 0);
      mem[i] = (s < 6) ? 8'(s) : (s < 8) ? 8'h10 : 8'($urandom);
    end
  endtask

  initial begin
    int k;
    fill_random();
    #1;
    check("rst_outputs", {mem_req, dec_valid, illegal, opcode, operand1, operand2, operand3, pc, dbg_state},
          {3'b000, 40'h0, ST_OP});

    // 4-byte instruction, zero wait states, cycle-accurate valid
    mem[0] = 8'h00; mem[1] = 8'h11; mem[2] = 8'h22; mem[3] = 8'h35;
    model_run(8'h00, 1);
    release_reset();
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk); #1;
      if (i == 1) check("first_req", {mem_req, mem_addr}, {1'b1, 8'h00});
      check("valid_cycle", dec_valid, (i == 5));
    end
    wait_drain(100);
    check_end();

    // 3-byte instruction held by back-pressure
    assert_reset();
    fill_random();
    mem[0] = 8'h05; mem[1] = 8'hAA; mem[2] = 8'h03;
    ready_pct = 0;
    model_run(8'h00, 1);
    release_reset();
    k = 0;
    while (!dec_valid && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check("valid_seen", dec_valid, 1);
    repeat (3) begin
      @(negedge clk); #1;
      check("issue_held", {dec_valid, pc}, {1'b1, 8'h00});
    end
    ready_pct = 100;
    wait_drain(100);
    check_end();

    // JMP resolved internally
    assert_reset();
    fill_random();
    mem[8'h00] = 8'h10; mem[8'h01] = 8'h40;
    mem[8'h40] = 8'h01; mem[8'h41] = 8'h07; mem[8'h42] = 8'h08; mem[8'h43] = 8'h09;
    model_run(8'h00, 1);
    release_reset();
    wait_drain(100);
    check_end();

    // Instruction straddling the top of memory
    assert_reset();
    fill_random();
    mem[8'h00] = 8'h10; mem[8'h01] = 8'hFE;
    mem[8'hFE] = 8'h02; mem[8'hFF] = 8'h0F;
    model_run(8'h00, 1);
    release_reset();
    wait_drain(100);
    check_end();

    // Illegal opcode
    assert_reset();
    fill_random();
    mem[8'h00] = 8'h7E;
    model_run(8'h00, 1);
    release_reset();
    wait_drain(100);
    check_end();

    // Reset during B2 with wait states pending
    assert_reset();
    fill_random();
    mem[0] = 8'h00; mem[1] = 8'h11; mem[2] = 8'h22; mem[3] = 8'h35;
    wait_min = 2; wait_max = 2; spurious = 1;
    release_reset();
    k = 0;
    while (!(mem_req && mem_addr == 8'h02) && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check("reach_b2", {mem_req, mem_addr}, {1'b1, 8'h02});
    #1 rst_n = 1'b0;
    #1;
    check("async_clear", {mem_req, dec_valid, opcode, operand1, operand2, pc}, 42'h0);
    exp_q.delete();
    model_run(8'h00, 1);
    release_reset();
    wait_drain(200);
    check_end();

    // Randomized programs, wait states and back-pressure
    for (int r = 0; r < 12; r++) begin
      assert_reset();
      fill_random();
      wait_min = 0;
      wait_max = $urandom_range(3, 0);
      ready_pct = $urandom_range(100, 30);
      spurious = 1;
      model_run(8'h00, 12);
      release_reset();
      wait_drain(3000);
      check_end();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cisc_fetch_decode.md
# cisc_fetch_decode

Front-end stage of the CISC processor: fetches variable-length, byte-encoded instructions from a byte-wide instruction memory and assembles them into the `opcode`/`operand1`/`operand2`/`operand3` bundle consumed by the execute stage. It also resolves unconditional jumps internally, without issuing them. It sits directly upstream of the ALU/execute block and drives its inputs through a valid/ready handshake.

## Interface
- `RESET_PC`, default 8'h00: fetch address after reset.
- `ADDR_W`, default 8: instruction address width; the PC wraps modulo 2^ADDR_W.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mem_req`  out  1  instruction byte request.
- `mem_addr`  out  ADDR_W  byte address; stable while `mem_req` is high and `mem_ack` is low.
- `mem_ack`  in  1  memory returns `mem_rdata` this cycle; the request completes.
- `mem_rdata`  in  8  instruction byte, valid when `mem_ack` is high.
- `dec_valid`  out  1  decoded bundle is valid.
- `dec_ready`  in  1  execute stage accepts the bundle.
- `opcode`, `operand1`, `operand2`  out  8 each  decoded fields.
- `operand3`  out  8  destination register index; bits [7:4] are always 0.
- `pc`  out  ADDR_W  address of the opcode byte of the instruction being fetched or held.
- `illegal`  out  1  sticky illegal-opcode flag (only with the macro; tied to 0 without it).

## Operation
- Encodings:
  - 0x00–0x04: 4 bytes, `op a b d`.
  - 0x05: 3 bytes, `op a d`; `operand2` is issued as 0.
  - 0x10 JMP: 2 bytes, `op t`; sets pc = t and is never issued.
  - Any other opcode is illegal.
- FSM states: OP, B1, B2, B3, ISSUE, HALT (HALT exists only with the macro).
- OP: request at `pc`; on ack, latch the opcode and compute its length.
  - Length 4 or 3: go to B1.
  - JMP: go to B1.
  - Illegal: see Configuration.
- B1: request at pc+1; on ack:
  - JMP: pc ← byte, go to OP.
  - Otherwise latch `operand1`; length 3 → B3, length 4 → B2.
- B2: request at pc+2; latch `operand2` on ack; go to B3.
- B3: request at pc+len-1; latch `operand3` = {4'h0, byte[3:0]}; go to ISSUE.
- ISSUE: `dec_valid` = 1 and outputs held stable.
  - When `dec_ready` is high: pc ← pc+len (mod 2^ADDR_W), go to OP.
- All address arithmetic is ADDR_W-bit and wraps; an instruction may straddle the top of memory (e.g. pc=FE, len=4 fetches FE, FF, 00, 01).
- `mem_req` is 0 in ISSUE and HALT.
- Only one request is outstanding at a time.

## Timing
- Reset, asynchronous on `rst_n` low: state=OP, pc=RESET_PC, `dec_valid`=0, `opcode`/`operand1`/`operand2`/`operand3`=0, `illegal`=0, `mem_req`=0.
- `mem_req` rises in the first cycle after reset release.
- Each byte takes 1 cycle if `mem_ack` returns in the request cycle; wait states stretch the state with no other effect.
- Minimum issue spacing: 4-byte instruction 5 cycles; 3-byte instruction 4 cycles; JMP costs 2 cycles with no issue.
- `dec_valid` rises the cycle after the last-byte ack.
- Bundle handoff occurs in the cycle where `dec_valid` and `dec_ready` are both high; the next `mem_req` is asserted in the following cycle.
- `dec_ready` high before `dec_valid` has no effect.
- `dec_valid` never drops without a handshake except on reset.
- Reset mid-fetch or mid-ISSUE: the bundle is discarded and any pending request is abandoned; late `mem_ack` is ignored while `mem_req` is 0.

## Configuration
- `CISC_FETCH_ILLEGAL_TRAP_EN` defined:
  - An illegal opcode sets `illegal` = 1 (sticky) and enters HALT.
  - HALT: no requests, `dec_valid` = 0, `pc` frozen at the offending byte.
  - Only reset exits HALT.
- Not defined:
  - An illegal opcode is a 1-byte instruction issued with operands 0; execute treats it as its default case.
  - pc advances by 1.
  - `illegal` is tied to 0.

## Structure
- Shared package `cisc_pkg` holds:
  - Opcode constants (OP_ADD..OP_NOT, OP_JMP).
  - FSM state enum.
  - Instruction-length function.
- The execute stage imports the same opcode constants.
- One combinational sub-module, `cisc_opcode_len`: opcode → {length[2:0], is_jmp, is_illegal}.

## Test plan
- Memory 00 11 22 35, zero-wait ack: one issue of opcode=00, op1=11, op2=22, op3=05; `dec_valid` in cycle 5; next fetch at pc=04.
- 05 AA 03 with `dec_ready` held low for 3 cycles: opcode=05, op1=AA, op2=00, op3=03 stable throughout; pc advances to +3 only after the handshake.
- 10 40 at 00, 01 07 08 09 at 40: no issue for the JMP; next issue is opcode=01 fetched from 40–43.
- RESET_PC=FE, bytes 02 0F F0 01 at FE/FF/00/01: addresses wrap; issue 02/0F/F0/01; next pc=02.
- Opcode 7E: with the macro, `illegal`=1, HALT, `mem_req` stays 0 for 20 cycles; without it, issue 7E/00/00/00 and pc+1.
- `rst_n` low during B2 with 2 wait states pending: all outputs zero immediately; refetch from RESET_PC after release.
